// File: rtl/fastpath_div_pkg.sv
// Shared types and helpers for the fast-path divider: FSM states, the
// reciprocal divisor set, and the power-of-two / reciprocal helpers.
package fastpath_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RMUL = 2'd1,
        RCOR = 2'd2,
        ITER = 2'd3
    } state_t;

    localparam int N_CONST = 8;
    localparam int unsigned CONST_DIVS [N_CONST] = '{3, 5, 6, 7, 9, 10, 100, 1000};

    typedef struct packed {
        logic       pow2;
        logic [6:0] k;
    } pow2_t;

    // floor(2^wid / d); wide enough for the largest supported WID.
    function automatic logic [127:0] recip(input int wid, input logic [127:0] d);
        logic [128:0] num;
        num = 129'd1 << wid;
        if (d == '0) begin
            return '1;
        end
        return 128'(num / {1'b0, d});
    endfunction

    function automatic pow2_t log2_pow2(input logic [127:0] v);
        pow2_t res;
        res.pow2 = (v != '0) && ((v & (v - 128'd1)) == '0);
        res.k    = '0;
        for (int i = 0; i < 128; i++) begin
            if (v[i]) begin
                res.k = 7'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fastpath_div_recip_lut.sv
// Combinational map from a divisor to its precomputed reciprocal, with a
// hit flag when the divisor belongs to the constant set.
module fastpath_div_recip_lut
    import fastpath_div_pkg::*;
#(
    parameter int WID = 64
) (
    input  logic [WID-1:0] b,
    output logic           hit,
    output logic [WID-1:0] m
);

    logic [N_CONST-1:0] hit_vec;
    logic [WID-1:0]     m_tab [N_CONST];

    generate
        for (genvar gi = 0; gi < N_CONST; gi++) begin : g_const
            localparam logic [127:0] DIV    = 128'(CONST_DIVS[gi]);
            localparam logic [127:0] M_FULL = recip(WID, DIV);
            // Wide compare so constants above the operand range never alias.
            assign hit_vec[gi] = (128'(b) == DIV);
            assign m_tab[gi]   = M_FULL[WID-1:0];
        end
    endgenerate

    always_comb begin
        hit = |hit_vec;
        m   = '0;
        for (int i = 0; i < N_CONST; i++) begin
            if (hit_vec[i]) begin
                m = m_tab[i];
            end
        end
    end

endmodule

// File: rtl/fastpath_divider.sv
// Multicycle unsigned divider: trivial divisors finish in one cycle, a fixed
// constant set uses reciprocal multiply plus correction, the rest iterate.
module fastpath_divider
    import fastpath_div_pkg::*;
#(
    parameter int WID = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic [WID-1:0] q,
    output logic [WID-1:0] r,
    output logic           busy,
    output logic           done,
    output logic           dbz,
    output logic           fast
);

    localparam int CW = $clog2(WID + 1);

    state_t         state;
    logic [WID-1:0] a_reg;
    logic [WID-1:0] b_reg;
    logic [WID-1:0] m_reg;
    logic [WID-1:0] q0_reg;
    logic [WID-1:0] pr_reg;
    logic [CW-1:0]  cnt;

    logic           lut_hit;
    logic [WID-1:0] lut_m;
    pow2_t          b_info;

    fastpath_div_recip_lut #(.WID(WID)) u_lut (
        .b   (b),
        .hit (lut_hit),
        .m   (lut_m)
    );

    assign b_info = log2_pow2(128'(b));

    // Reciprocal path: q0 is the exact quotient or one short of it.
    logic [2*WID-1:0] prod;
    logic [WID-1:0]   q0;
    logic [WID-1:0]   r0;
    assign prod = {{WID{1'b0}}, a_reg} * {{WID{1'b0}}, m_reg};
    assign q0   = prod[2*WID-1:WID];
    assign r0   = a_reg - b_reg * q0_reg;

    // Restoring step; a_reg shifts dividend bits out and quotient bits in.
    logic [WID:0]   pr_shift;
    logic [WID:0]   pr_diff;
    logic           q_bit;
    logic [WID-1:0] pr_new;
    logic [WID-1:0] quo_new;
    assign pr_shift = {pr_reg, a_reg[WID-1]};
    assign pr_diff  = pr_shift - {1'b0, b_reg};
    assign q_bit    = ~pr_diff[WID];
    assign pr_new   = q_bit ? pr_diff[WID-1:0] : pr_shift[WID-1:0];
    assign quo_new  = {a_reg[WID-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            m_reg  <= '0;
            q0_reg <= '0;
            pr_reg <= '0;
            cnt    <= '0;
            q      <= '0;
            r      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            fast   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        a_reg <= a;
                        b_reg <= b;
                        if (b == '0) begin
                            q    <= '1;
                            r    <= a;
                            dbz  <= 1'b1;
                            fast <= 1'b1;
                            done <= 1'b1;
                        end else if (a == '0) begin
                            q    <= '0;
                            r    <= '0;
                            dbz  <= 1'b0;
                            fast <= 1'b1;
                            done <= 1'b1;
                        end else if (b == WID'(1)) begin
                            q    <= a;
                            r    <= '0;
                            dbz  <= 1'b0;
                            fast <= 1'b1;
                            done <= 1'b1;
                        end else if (b_info.pow2) begin
                            q    <= a >> b_info.k;
                            r    <= a & (b - WID'(1));
                            dbz  <= 1'b0;
                            fast <= 1'b1;
                            done <= 1'b1;
                        end else if (lut_hit) begin
                            m_reg <= lut_m;
                            busy  <= 1'b1;
                            state <= RMUL;
                        end else begin
                            pr_reg <= '0;
                            cnt    <= CW'(WID);
                            busy   <= 1'b1;
                            state  <= ITER;
                        end
                    end
                end
                RMUL: begin
                    q0_reg <= q0;
                    state  <= RCOR;
                end
                RCOR: begin
                    if (r0 >= b_reg) begin
                        q <= q0_reg + WID'(1);
                        r <= r0 - b_reg;
                    end else begin
                        q <= q0_reg;
                        r <= r0;
                    end
                    dbz   <= 1'b0;
                    fast  <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ITER: begin
                    pr_reg <= pr_new;
                    a_reg  <= quo_new;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        q     <= quo_new;
                        r     <= pr_new;
                        dbz   <= 1'b0;
                        fast  <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fastpath_divider.sv
// Randomized self-checking bench for fastpath_divider at WID=32, checked
// against plain integer division and the path-selection rules.
module tb_fastpath_divider;

    localparam int WID = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ld;
    logic [WID-1:0] a;
    logic [WID-1:0] b;
    logic [WID-1:0] q;
    logic [WID-1:0] r;
    logic           busy;
    logic           done;
    logic           dbz;
    logic           fast;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fastpath_divider #(.WID(WID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .fast  (fast)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] av, input logic [31:0] bv);
        if (bv == 0 || av == 0 || $countones(bv) == 1) return 1;
        if (bv inside {3, 5, 6, 7, 9, 10, 100, 1000}) return 3;
        return WID + 1;
    endfunction

    // Starts at a negedge with the DUT idle (or in its done cycle); returns
    // at the negedge of the done cycle so calls chain back-to-back.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input bit noise);
        logic [31:0] eq, er;
        int elat, lat, busy_cnt;
        if (bv == 0) begin
            eq = '1;
            er = av;
        end else begin
            eq = av / bv;
            er = av % bv;
        end
        elat = exp_latency(av, bv);
        ld = 1'b1;
        a  = av;
        b  = bv;
        @(negedge clk);
        ld = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            if (noise && busy) begin
                ld = 1'($urandom_range(0, 1));
                a  = $urandom;
                b  = $urandom;
            end else begin
                ld = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        ld = 1'b0;
        check("latency", 64'(lat), 64'(elat));
        check("q", 64'(q), 64'(eq));
        check("r", 64'(r), 64'(er));
        check("dbz", 64'(dbz), 64'(bv == 0));
        check("fast", 64'(fast), 64'(elat != WID + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(elat - 1));
        check("busy_at_done", 64'(busy), 64'(0));
        $display("op a=%08h b=%08h q=%08h r=%08h dbz=%0b fast=%0b lat=%0d",
                 av, bv, q, r, dbz, fast, lat);
    endtask

    initial begin
        logic [31:0] ra, rb, hold_q;
        logic [31:0] consts [8];
        consts = '{3, 5, 6, 7, 9, 10, 100, 1000};

        rst_n = 1'b0;
        ld    = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_q", 64'(q), 64'(0));
        check("rst_r", 64'(r), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dbz", 64'(dbz), 64'(0));
        check("rst_fast", 64'(fast), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd100, 32'd0, 1'b0);
        do_op(32'd353, 32'd9, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd3, 1'b0);
        check("q_corrected", 64'(q), 64'h5555_5555);
        do_op(32'h0400_0000, 32'd101, 1'b1);
        check("q_iter", 64'(q), 64'd664444);
        check("r_iter", 64'(r), 64'd20);
        do_op(32'd1000, 32'd64, 1'b0);
        do_op(32'd7, 32'd7, 1'b1);
        @(negedge clk);
        check("q_hold", 64'(q), 64'd1);

        // Abort mid-iteration with reset.
        ld = 1'b1;
        a  = 32'h0400_0000;
        b  = 32'd101;
        @(negedge clk);
        ld = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_q", 64'(q), 64'(0));
        check("abort_r", 64'(r), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_fast", 64'(fast), 64'(0));
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'd10, 32'd1, 1'b0);
        check("q_after_abort", 64'(q), 64'd10);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'd1 << $urandom_range(0, 31);
                2: rb = consts[$urandom_range(0, 7)];
                3: rb = $urandom_range(2, 20);
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: ra = $urandom_range(0, 1000);
                default: ra = $urandom;
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                hold_q = (rb == 0) ? 32'hFFFF_FFFF : ra / rb;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("q_hold_gap", 64'(q), 64'(hold_q));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
